// File: rtl/axi_mem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the AXI master.
// slave: arbiter side; master: requester/master side.
interface axi_mem_arbiter_if;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        mst_start;
    logic        mst_rw;
    logic [31:0] mst_addr;
    logic [31:0] mst_wdata;
    logic [3:0]  mst_wstrb;
    logic        mst_done;
    logic [31:0] mst_rdata;
    logic        mst_busy;
    logic        owner;
    logic        arb_busy;

    modport slave (
        input  d_req, d_rw, d_addr, d_wdata, d_wstrb,
        output d_ack, d_rdata,
        input  i_req, i_addr,
        output i_ack, i_rdata,
        output mst_start, mst_rw, mst_addr,
        output mst_wdata, mst_wstrb,
        input  mst_done, mst_rdata, mst_busy,
        output owner, arb_busy
    );

    modport master (
        output d_req, d_rw, d_addr, d_wdata, d_wstrb,
        input  d_ack, d_rdata,
        output i_req, i_addr,
        input  i_ack, i_rdata,
        input  mst_start, mst_rw, mst_addr,
        input  mst_wdata, mst_wstrb,
        output mst_done, mst_rdata, mst_busy,
        input  owner, arb_busy
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Two-port arbiter (data / fetch) in front of a single-outstanding
// AXI master: data priority with a fetch starvation guard.
module axi_mem_arbiter #(
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned STARVE_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_mem_arbiter_if.slave bus
);

    typedef enum logic {IDLE, WAIT} state_e;

    localparam logic [STARVE_W-1:0] MAX_S =
        STARVE_W'(MAX_STARVE);

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                start_q, start_d;
    logic                rw_q, rw_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                owner_q, owner_d;
    logic                d_ack_q, d_ack_d;
    logic                i_ack_q, i_ack_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic [31:0]         i_rdata_q, i_rdata_d;

    logic d_elig;
    logic i_elig;
    logic pick_i;
    logic grant;

    // A port acked this cycle is masked so it can drop req cleanly.
    assign d_elig = bus.d_req && !d_ack_q;
    assign i_elig = bus.i_req && !i_ack_q;
    assign pick_i = i_elig &&
                    (!d_elig || (starve_q >= MAX_S));
    assign grant  = (d_elig || i_elig) && !bus.mst_busy;

    // Next-state: grant in IDLE, complete on mst_done in WAIT.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        start_d   = 1'b0;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        owner_d   = owner_q;
        d_ack_d   = 1'b0;
        i_ack_d   = 1'b0;
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = WAIT;
                    start_d = 1'b1;
                    owner_d = pick_i;
                    if (pick_i) begin
                        rw_d     = 1'b0;
                        addr_d   = bus.i_addr;
                        wdata_d  = '0;
                        wstrb_d  = '0;
                        starve_d = '0;
                    end else begin
                        rw_d    = bus.d_rw;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        wstrb_d = bus.d_wstrb;
                        if (!i_elig)
                            starve_d = '0;
                        else if (starve_q < MAX_S)
                            starve_d = starve_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.mst_done) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.mst_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!rw_q)
                            d_rdata_d = bus.mst_rdata;
                    end
                end
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            start_q   <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            owner_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            start_q   <= start_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            owner_q   <= owner_d;
            d_ack_q   <= d_ack_d;
            i_ack_q   <= i_ack_d;
            d_rdata_q <= d_rdata_d;
            i_rdata_q <= i_rdata_d;
        end
    end

    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.mst_start = start_q;
    assign bus.mst_rw    = rw_q;
    assign bus.mst_addr  = addr_q;
    assign bus.mst_wdata = wdata_q;
    assign bus.mst_wstrb = wstrb_q;
    assign bus.owner     = owner_q;
    assign bus.arb_busy  = (state_q == WAIT);

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter with a small
// auto-responding master model.
module tb_axi_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_arbiter_if bus ();

    axi_mem_arbiter #(
        .MAX_STARVE(4),
        .STARVE_W  (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic        auto_en = 1'b1;
    logic        tail = 1'b0;
    logic        auto_done = 1'b0;
    logic        auto_busy = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_done = 1'b0;
    logic        man_busy = 1'b0;
    logic [31:0] man_rdata = '0;

    assign bus.mst_done  = auto_done | man_done;
    assign bus.mst_busy  = auto_busy | man_busy;
    assign bus.mst_rdata = auto_done ? auto_rdata : man_rdata;

    logic        g_own[$];
    logic [31:0] g_addr[$];
    logic        g_rw[$];
    logic [31:0] g_wdata[$];
    logic [3:0]  g_wstrb[$];
    int          g_cyc[$];
    int          n_dack = 0;
    int          n_iack = 0;
    int          dack_cyc = 0;
    int          iack_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] resp(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Log grants and acks as seen between edges.
    always @(negedge clk) begin
        if (bus.mst_start) begin
            g_own.push_back(bus.owner);
            g_addr.push_back(bus.mst_addr);
            g_rw.push_back(bus.mst_rw);
            g_wdata.push_back(bus.mst_wdata);
            g_wstrb.push_back(bus.mst_wstrb);
            g_cyc.push_back(cyc);
        end
        if (bus.d_ack) begin
            n_dack++;
            dack_cyc = cyc;
        end
        if (bus.i_ack) begin
            n_iack++;
            iack_cyc = cyc;
        end
    end

    // Master model: done 3 cycles after start is seen; optional
    // one-cycle busy tail after done.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (auto_en && bus.mst_start) begin
                a = bus.mst_addr;
                repeat (3) @(negedge clk);
                auto_done  = 1'b1;
                auto_rdata = resp(a);
                if (tail) auto_busy = 1'b1;
                @(negedge clk);
                auto_done = 1'b0;
                if (auto_busy) begin
                    @(negedge clk);
                    auto_busy = 1'b0;
                end
            end
        end
    end

    task automatic serve(input int nd, input int ni, input bit keep);
        int gd;
        int gi;
        gd = 0;
        gi = 0;
        for (int k = 0; k < 300 && (gd < nd || gi < ni); k++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                gd++;
                if (!(keep && gd < nd)) bus.d_req = 1'b0;
            end
            if (bus.i_ack) begin
                gi++;
                bus.i_req = 1'b0;
            end
        end
        chk("serve_done", {30'd0, gd >= nd, gi >= ni}, 32'd3);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int base;
        int rc;
        int da0;
        int ia0;
        logic [5:0] ord;

        bus.d_req   = 1'b0;
        bus.d_rw    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;

        repeat (3) @(negedge clk);
        chk("rst_dack", bus.d_ack, 0);
        chk("rst_iack", bus.i_ack, 0);
        chk("rst_drd", bus.d_rdata, 0);
        chk("rst_ird", bus.i_rdata, 0);
        chk("rst_start", bus.mst_start, 0);
        chk("rst_addr", bus.mst_addr, 0);
        chk("rst_busy", bus.arb_busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single fetch
        base = g_own.size();
        da0 = n_dack;
        ia0 = n_iack;
        bus.i_addr = 32'h100;
        bus.i_req  = 1'b1;
        rc = cyc;
        serve(0, 1, 0);
        chk("f_ngrant", g_own.size() - base, 1);
        chk("f_rw", g_rw[base], 0);
        chk("f_addr", g_addr[base], 32'h100);
        chk("f_lat_st", g_cyc[base] - rc, 1);
        chk("f_lat_ack", iack_cyc - g_cyc[base], 4);
        chk("f_rdata", bus.i_rdata, 32'h0050_0093);
        chk("f_dack", n_dack - da0, 0);
        chk("f_iack", n_iack - ia0, 1);

        // data read then data write
        bus.d_addr = 32'h300;
        bus.d_rw   = 1'b0;
        bus.d_req  = 1'b1;
        serve(1, 0, 0);
        chk("dr_rdata", bus.d_rdata, 32'h5A5A_0300);

        base = g_own.size();
        ia0 = n_iack;
        bus.d_rw    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_wstrb = 4'hF;
        bus.d_req   = 1'b1;
        serve(1, 0, 0);
        bus.d_rw = 1'b0;
        chk("w_rw", g_rw[base], 1);
        chk("w_addr", g_addr[base], 32'h2000);
        chk("w_wdata", g_wdata[base], 32'hDEAD_BEEF);
        chk("w_wstrb", g_wstrb[base], 4'hF);
        chk("w_owner", g_own[base], 0);
        chk("w_rdata_keep", bus.d_rdata, 32'h5A5A_0300);
        chk("w_iack", n_iack - ia0, 0);

        // contention
        base = g_own.size();
        da0 = n_dack;
        ia0 = n_iack;
        bus.d_addr = 32'h400;
        bus.i_addr = 32'h500;
        bus.d_req  = 1'b1;
        bus.i_req  = 1'b1;
        serve(1, 1, 0);
        chk("c_ngrant", g_own.size() - base, 2);
        chk("c_own0", g_own[base], 0);
        chk("c_addr0", g_addr[base], 32'h400);
        chk("c_own1", g_own[base+1], 1);
        chk("c_addr1", g_addr[base+1], 32'h500);
        chk("c_b2b", g_cyc[base+1] - dack_cyc, 1);
        chk("c_dack", n_dack - da0, 1);
        chk("c_iack", n_iack - ia0, 1);
        chk("c_drd", bus.d_rdata, 32'h5A5A_0400);
        chk("c_ird", bus.i_rdata, 32'h5A5A_0500);

        // starvation guard
        tail = 1'b1;
        base = g_own.size();
        da0 = n_dack;
        ia0 = n_iack;
        bus.d_addr = 32'h800;
        bus.i_addr = 32'h900;
        bus.d_req  = 1'b1;
        bus.i_req  = 1'b1;
        serve(5, 1, 1);
        tail = 1'b0;
        repeat (2) @(negedge clk);
        chk("s_ngrant", g_own.size() - base, 6);
        ord = '0;
        for (int k = 0; k < 6; k++)
            ord = {ord[4:0], g_own[base+k]};
        chk("s_order", ord, 6'b000010);
        chk("s_cnt0", dut.starve_q, 0);
        chk("s_dack", n_dack - da0, 5);
        chk("s_iack", n_iack - ia0, 1);

        // master busy blocks grants
        base = g_own.size();
        man_busy = 1'b1;
        bus.d_addr = 32'h600;
        bus.d_req  = 1'b1;
        repeat (5) @(negedge clk);
        chk("b_nogrant", g_own.size() - base, 0);
        chk("b_idle", bus.arb_busy, 0);
        man_busy = 1'b0;
        rc = cyc;
        serve(1, 0, 0);
        chk("b_lat", g_cyc[base] - rc, 1);
        chk("b_rdata", bus.d_rdata, 32'h5A5A_0600);

        // spurious done in IDLE
        base = g_own.size();
        da0 = n_dack;
        ia0 = n_iack;
        man_rdata = 32'h1234_5678;
        man_done  = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("sp_dack", n_dack - da0, 0);
        chk("sp_iack", n_iack - ia0, 0);
        chk("sp_grant", g_own.size() - base, 0);
        chk("sp_drd", bus.d_rdata, 32'h5A5A_0600);
        chk("sp_ird", bus.i_rdata, 32'h5A5A_0900);

        // reset while waiting on the master
        auto_en = 1'b0;
        base = g_own.size();
        bus.i_addr = 32'h700;
        bus.i_req  = 1'b1;
        for (int k = 0; k < 10 && !bus.arb_busy; k++)
            @(negedge clk);
        chk("r_wait", bus.arb_busy, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("r_busy", bus.arb_busy, 0);
        chk("r_owner", bus.owner, 0);
        chk("r_addr", bus.mst_addr, 0);
        chk("r_ird", bus.i_rdata, 0);
        chk("r_drd", bus.d_rdata, 0);
        chk("r_iack", bus.i_ack, 0);
        bus.i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ia0 = n_iack;
        repeat (6) @(negedge clk);
        chk("r_noack", n_iack - ia0, 0);
        chk("r_ngrant", g_own.size() - base, 1);

        auto_en = 1'b1;
        base = g_own.size();
        bus.i_addr = 32'h100;
        bus.i_req  = 1'b1;
        serve(0, 1, 0);
        chk("r2_ngrant", g_own.size() - base, 1);
        chk("r2_addr", g_addr[base], 32'h100);
        chk("r2_ird", bus.i_rdata, 32'h0050_0093);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
